// File: rtl/try_pkg.sv
// Shared decode constants, ALU operation encoding and the seven-segment
// lookup used by the RV32I-subset demo core.
package try_pkg;

    // Major opcodes handled by the core
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct3 for OP / OP_IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_PASSB
    } alu_op_e;

    // Active-low segment pattern, bit0 = a ... bit6 = g
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/try_if.sv
// Board-side I/O of the demo: register-select switches in, one digit out.
interface try_if;
    logic [4:0] sw;
    logic [6:0] HEX4;

    modport master (output sw, input HEX4);
    modport slave  (input sw, output HEX4);
endinterface

// File: rtl/try_regfile.sv
// 32 x XLEN register file: two execute read ports, one display read port
// (low nibble only, that is all the digit shows), one synchronous write port.
module try_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd2,
    input  logic [4:0]      ra3,
    output logic [3:0]      rd3
);

    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] disp_word;

    // Write-back; x0 is never written so it stays at its reset value of 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Combinational reads with x0 forced to zero
    always_comb begin
        rd1       = (ra1 == 5'd0) ? '0 : regs[ra1];
        rd2       = (ra2 == 5'd0) ? '0 : regs[ra2];
        disp_word = (ra3 == 5'd0) ? '0 : regs[ra3];
        rd3       = disp_word[3:0];
    end

endmodule

// File: rtl/try_top.sv
// Board wrapper around a single-cycle RV32I-subset core running a fixed ROM
// program; the switches pick a register whose low nibble drives HEX4.
module try_top
    import try_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    try_if.slave  io
);

    localparam int          IDX_W   = $clog2(IMEM_DEPTH);
    localparam logic [XLEN-1:0] PC_MASK = XLEN'(IMEM_DEPTH * 4 - 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_a, rs1_a, rs2_a;

    logic [XLEN-1:0] imm_i, imm_b, imm_j, imm_u;
    logic [XLEN-1:0] rs1_v, rs2_v, op_b, alu_res, wb_data;
    logic [3:0]      disp_nib;

    alu_op_e alu_op;
    logic    use_imm;
    logic    use_u;
    logic    rf_we;
    logic    is_branch;
    logic    br_ne;
    logic    is_jal;
    logic    br_taken;

    logic signed [XLEN-1:0] a_s, b_s;

    // PC register; the mask keeps it inside the ROM window so it wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next & PC_MASK;
        end
    end

    // Instruction ROM holding the demo program
    always_comb begin
        instr = 32'h0000_0000;
        case (pc[IDX_W+1:2])
            5'd0:  instr = 32'h0050_0093; // addi x1,x0,5
            5'd1:  instr = 32'h0030_0113; // addi x2,x0,3
            5'd2:  instr = 32'h0020_81B3; // add  x3,x1,x2
            5'd3:  instr = 32'h4020_8233; // sub  x4,x1,x2
            5'd4:  instr = 32'h0020_F2B3; // and  x5,x1,x2
            5'd5:  instr = 32'h0020_E333; // or   x6,x1,x2
            5'd6:  instr = 32'h0020_C3B3; // xor  x7,x1,x2
            5'd7:  instr = 32'h0011_2433; // slt  x8,x2,x1
            5'd8:  instr = 32'h0014_8493; // addi x9,x9,1
            5'd9:  instr = 32'hFE14_9EE3; // bne  x9,x1,-4
            5'd10: instr = 32'hFFF0_0593; // addi x11,x0,-1
            5'd11: instr = 32'h0000_006F; // jal  x0,0
            default: instr = 32'h0000_0000;
        endcase
    end

    // Field extraction and sign-extended immediates
    always_comb begin
        opcode = instr[6:0];
        rd_a   = instr[11:7];
        funct3 = instr[14:12];
        rs1_a  = instr[19:15];
        rs2_a  = instr[24:20];
        funct7 = instr[31:25];
        imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
        imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_j  = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_u  = {instr[31:12], 12'b0};
    end

    // Decoder; anything not recognised leaves rf_we low and falls through to PC+4
    always_comb begin
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        use_u     = 1'b0;
        rf_we     = 1'b0;
        is_branch = 1'b0;
        br_ne     = 1'b0;
        is_jal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    rf_we = 1'b1;
                    case (funct3)
                        F3_ADD_SUB: alu_op = ALU_ADD;
                        F3_SLL:     alu_op = ALU_SLL;
                        F3_SLT:     alu_op = ALU_SLT;
                        F3_XOR:     alu_op = ALU_XOR;
                        F3_SRL:     alu_op = ALU_SRL;
                        F3_OR:      alu_op = ALU_OR;
                        F3_AND:     alu_op = ALU_AND;
                        default:    rf_we  = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    rf_we  = 1'b1;
                    alu_op = ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                rf_we   = 1'b1;
                case (funct3)
                    F3_ADD_SUB: alu_op = ALU_ADD;
                    F3_SLT:     alu_op = ALU_SLT;
                    F3_XOR:     alu_op = ALU_XOR;
                    F3_OR:      alu_op = ALU_OR;
                    F3_AND:     alu_op = ALU_AND;
                    default:    rf_we  = 1'b0;
                endcase
            end
            OPC_LUI: begin
                use_u  = 1'b1;
                alu_op = ALU_PASSB;
                rf_we  = 1'b1;
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    is_branch = 1'b1;
                    br_ne     = (funct3 == F3_BNE);
                end
            end
            OPC_JAL: begin
                is_jal = 1'b1;
                rf_we  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU with signed compare for SLT/SLTI
    always_comb begin
        op_b    = use_u ? imm_u : (use_imm ? imm_i : rs2_v);
        a_s     = rs1_v;
        b_s     = op_b;
        alu_res = '0;
        case (alu_op)
            ALU_ADD:   alu_res = rs1_v + op_b;
            ALU_SUB:   alu_res = rs1_v - op_b;
            ALU_AND:   alu_res = rs1_v & op_b;
            ALU_OR:    alu_res = rs1_v | op_b;
            ALU_XOR:   alu_res = rs1_v ^ op_b;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLL:   alu_res = rs1_v << op_b[4:0];
            ALU_SRL:   alu_res = rs1_v >> op_b[4:0];
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = '0;
        endcase
    end

    // Next-PC selection and write-back data
    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        br_taken = is_branch && ((rs1_v == rs2_v) != br_ne);
        if (is_jal) begin
            pc_next = pc + imm_j;
        end else if (br_taken) begin
            pc_next = pc + imm_b;
        end else begin
            pc_next = pc_plus4;
        end
        wb_data = is_jal ? pc_plus4 : alu_res;
    end

    try_regfile #(.XLEN(XLEN)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we),
        .waddr (rd_a),
        .wdata (wb_data),
        .ra1   (rs1_a),
        .rd1   (rs1_v),
        .ra2   (rs2_a),
        .rd2   (rs2_v),
        .ra3   (io.sw),
        .rd3   (disp_nib)
    );

    // Display digit follows the switches and register contents combinationally
    always_comb begin
        io.HEX4 = seg7(disp_nib);
    end

endmodule

// File: tb/tb_try_top.sv
// Directed bench for the RV32I-subset demo: reset display, loop progress,
// final register sweep, mid-run reset and combinational switch tracking.
module tb_try_top;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    try_if bus ();

    try_top #(.XLEN(32), .IMEM_DEPTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived segment codes for hex digits 0..F
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Expected display for x1..x11 once the program has finished
    logic [6:0] final_tab [1:11] = '{7'h12, 7'h30, 7'h00, 7'h24, 7'h79, 7'h78,
                                     7'h02, 7'h79, 7'h12, 7'h40, 7'h0E};

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: HEX4=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic show(input logic [4:0] s, input string tag, input logic [6:0] exp);
        bus.sw = s;
        #1;
        check(tag, bus.HEX4, exp);
    endtask

    task automatic sweep_final(input string pfx);
        for (int r = 1; r <= 11; r++) begin
            show(5'(r), $sformatf("%s_x%0d", pfx, r), final_tab[r]);
        end
        show(5'd13, {pfx, "_x13"}, 7'h40);
        show(5'd31, {pfx, "_x31"}, 7'h40);
        show(5'd0,  {pfx, "_x0"},  7'h40);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.sw   = 5'd0;

        // Reset held across edges
        repeat (2) @(posedge clk);
        #2;
        show(5'd0, "rst_x0", 7'h40);
        show(5'd1, "rst_x1", 7'h40);

        // Release between edges so the next rising edge is edge 1
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk);
            #2;
            if (e == 1)  show(5'd1, "e1_x1", 7'h12);
            if (e == 2)  show(5'd2, "e2_x2", 7'h30);
            if (e == 8)  show(5'd9, "e8_x9", 7'h40);
            if (e >= 9 && e <= 17 && (e % 2) == 1)
                show(5'd9, $sformatf("e%0d_x9", e), seg_tab[(e - 7) / 2]);
            if (e == 10) show(5'd9, "e10_x9", seg_tab[1]);
            if (e == 18) show(5'd11, "e18_x11", 7'h40);
            if (e == 19) show(5'd11, "e19_x11", 7'h0E);
        end
        sweep_final("run1");

        // Combinational tracking: several switch changes inside one half-cycle
        @(posedge clk);
        #1;
        show(5'd3, "comb_x3", 7'h00);
        show(5'd4, "comb_x4", 7'h24);
        show(5'd7, "comb_x7", 7'h02);
        show(5'd11, "comb_x11", 7'h0E);

        // Restart and assert reset asynchronously while the loop is running
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        show(5'd9, "mid_x9_pre", seg_tab[2]);
        reset = 1'b1;
        #1;
        show(5'd1, "mid_rst_x1", 7'h40);
        show(5'd9, "mid_rst_x9", 7'h40);
        show(5'd3, "mid_rst_x3", 7'h40);
        @(negedge clk);
        reset = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        sweep_final("run2");

        // Halt spin keeps the state stable
        repeat (6) @(posedge clk);
        #2;
        show(5'd9, "hold_x9", 7'h12);
        show(5'd11, "hold_x11", 7'h0E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/try_top.md
Name: try_top

Overview:
- Top-level FPGA wrapper around a minimal single-cycle RV32I-subset core. The core runs a fixed program from an internal instruction ROM.
- `sw[4:0]` selects one architectural register (x0..x31). The low nibble of that register drives one active-low seven-segment digit, `HEX4`.
- Used as the board-level demo of the processor datapath.

Parameters:
- XLEN, 32, datapath and register width.
- IMEM_DEPTH, 32, instruction ROM words; the PC indexes the ROM with PC[6:2].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears PC and all registers.
- sw  input  5  register index whose value is displayed.
- HEX4  output  7  seven-segment segments, active-low; bit0=a … bit6=g.

Behaviour:
- Reset (asynchronous, active-high):
  - PC=0 and x0..x31=0.
  - HEX4 therefore reads 7'h40 (digit 0) while reset is asserted.
- Single-cycle operation:
  - Each rising edge commits one instruction: register write-back and PC update.
  - ROM read and register-file read are combinational.
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLL, SRL.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI.
  - LUI, BEQ, BNE, JAL.
  - Any other encoding executes as a NOP: no write, PC+4.
- Immediates are sign-extended per RV32I. Shifts use rs2[4:0]. SLT/SLTI are signed compares.
- Branches:
  - Taken → PC + B-imm; not taken → PC+4.
  - JAL writes PC+4 to rd and sets PC = PC + J-imm.
- Writes to x0 are discarded; x0 always reads 0.
- The PC wraps modulo IMEM_DEPTH*4. No data memory and no loads/stores.
- Display:
  - HEX4 = seg(reg[sw][3:0]), purely combinational from `sw` and the current register contents.
  - A change on `sw` is reflected with no clock edge needed.
- Segment codes (hex digit → HEX4):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Fixed ROM program (word address: instruction); unlisted words are 0 (NOP):
  - 0: addi x1,x0,5
  - 1: addi x2,x0,3
  - 2: add x3,x1,x2
  - 3: sub x4,x1,x2
  - 4: and x5,x1,x2
  - 5: or x6,x1,x2
  - 6: xor x7,x1,x2
  - 7: slt x8,x2,x1
  - 8: addi x9,x9,1
  - 9: bne x9,x1,-4
  - 10: addi x11,x0,-1
  - 11: jal x0,0 (halt spin)
- Final state is reached by the 19th rising edge after reset release (8 + 10 + 1 instructions):
  - x1=5, x2=3, x3=8, x4=2, x5=1, x6=7, x7=6, x8=1, x9=5, x11=FFFFFFFF.
  - All other registers are 0.
- Reset mid-run: PC and registers clear immediately; the program restarts from address 0 on release.

Decomposition:
- Shared package `try_pkg`:
  - Opcode constants (OP, OP_IMM, LUI, BRANCH, JAL).
  - funct3/funct7 constants.
  - ALU-operation enum.
  - Seven-segment lookup function.
- Natural sub-module `try_regfile`: 32×XLEN registers, two combinational read ports plus a third read port for the display, one synchronous write port, async reset, x0 hardwired to 0.
- ALU, immediate generation, decoder and ROM live in the top.

Test Plan:
- Hold reset=1, sw=0 → HEX4=7'h40. Release, sw=1 after ≥1 edge → HEX4=7'h12 (x1=5).
- Run 25 cycles; sweep sw=1..11 → HEX4 = 12,30,00,24,79,78,02,79,12,40,0E (values 5,3,8,2,1,7,6,1,5,0,F).
- After the program completes: sw=5'b01101 and sw=5'b01011 → 7'h40 and 7'h0E respectively; sw=0 → 7'h40.
- Loop check: x9 increments 1..5 on consecutive passes through address 8. PC is 4 on edge 1 and 8 on edge 2; after edge 19 PC is 44 (address 11). PC stays at 44 every subsequent cycle.
- Assert reset for one cycle mid-loop → all sw selections read 7'h40 immediately. After release and 19 more edges, the final values match the sweep above.
- Toggle sw each half-cycle without clock edges → HEX4 tracks combinationally within the same timestep.
